// File: rtl/pipeline_hazard_scoreboard.sv
// Hazard/forwarding controller: in-flight writer scoreboard beside ID/EX, drives stall, bubble and EX forward selects.
// Latency: stall/id_bubble combinational from ID inputs; ex_fwd_a/b registered, valid while the instruction is in EX.
// Backpressure: stall holds PC and IF/ID; ex_flush overrides stall and kills the ID instruction.
module pipeline_hazard_scoreboard #(
  parameter int DEPTH    = 3,
  parameter int AW       = 5,
  parameter int ZERO_REG = 31,
  parameter int LOAD_LAT = 2,
  parameter int CW       = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     id_valid,
  input  logic [AW-1:0]            id_rn,
  input  logic [AW-1:0]            id_rm,
  input  logic                     id_rn_used,
  input  logic                     id_rm_used,
  input  logic                     id_wr_en,
  input  logic [AW-1:0]            id_rd,
  input  logic                     id_is_load,
  input  logic                     id_sets_flags,
  input  logic                     id_uses_flags,
  input  logic                     ex_flush,
  output logic                     stall,
  output logic                     id_bubble,
  output logic [$clog2(DEPTH)-1:0] ex_fwd_a,
  output logic [$clog2(DEPTH)-1:0] ex_fwd_b,
  output logic [CW-1:0]            stall_count,
  output logic [CW-1:0]            flush_count
);

  localparam int            SW     = $clog2(DEPTH);
  // Only stages 1..DEPTH-1 are stored: the WB-stage writer is covered by the
  // register file's falling-edge write, so it never forwards nor stalls.
  localparam int            NE     = DEPTH - 1;
  localparam logic [SW-1:0] LL_SEL = SW'(LOAD_LAT);
  localparam logic [AW-1:0] ZR     = AW'(ZERO_REG);

  // Scoreboard entries; index i tracks pipeline stage i+1.
  logic [NE-1:0] e_vld;
  logic [NE-1:0] e_wr;
  logic [NE-1:0] e_load;
  logic [AW-1:0] e_rd [NE];
  // Flags matter only for the instruction right in EX (B.cond reads NZVC in EX).
  logic          e0_flags;

  logic [SW-1:0] sel_a, sel_b;
  logic          load_a, load_b;
  logic          ld_haz, flag_haz;

  // Youngest matching writer per operand: scan oldest-to-youngest so the lowest index wins.
  always_comb begin
    sel_a  = '0;
    sel_b  = '0;
    load_a = 1'b0;
    load_b = 1'b0;
    for (int i = NE - 1; i >= 0; i--) begin
      if (id_rn_used && (id_rn != ZR) && e_vld[i] && e_wr[i] && (e_rd[i] == id_rn)) begin
        sel_a  = SW'(i + 1);
        load_a = e_load[i];
      end
      if (id_rm_used && (id_rm != ZR) && e_vld[i] && e_wr[i] && (e_rd[i] == id_rm)) begin
        sel_b  = SW'(i + 1);
        load_b = e_load[i];
      end
    end
  end

  // Load data is not ready until the end of stage LOAD_LAT; flags of the EX instruction are not yet written.
  assign ld_haz    = (load_a && (sel_a < LL_SEL)) || (load_b && (sel_b < LL_SEL));
  assign flag_haz  = id_uses_flags && e_vld[0] && e0_flags;
  assign stall     = reset && id_valid && !ex_flush && (ld_haz || flag_haz);
  assign id_bubble = !reset || stall || ex_flush || !id_valid;

  // Shift the scoreboard; the ID instruction enters stage 1 only when it advances.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      e_vld    <= '0;
      e_wr     <= '0;
      e_load   <= '0;
      e0_flags <= 1'b0;
      for (int i = 0; i < NE; i++) e_rd[i] <= '0;
    end else begin
      e_vld[0]  <= !id_bubble;
      e_wr[0]   <= !id_bubble && id_wr_en;
      e_load[0] <= !id_bubble && id_is_load;
      e_rd[0]   <= id_rd;
      e0_flags  <= !id_bubble && id_sets_flags;
      for (int i = 1; i < NE; i++) begin
        e_vld[i]  <= e_vld[i-1];
        e_wr[i]   <= e_wr[i-1];
        e_load[i] <= e_load[i-1];
        e_rd[i]   <= e_rd[i-1];
      end
    end
  end

  // Forward selects follow the instruction into EX; a bubble forwards nothing.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ex_fwd_a <= '0;
      ex_fwd_b <= '0;
    end else begin
      ex_fwd_a <= id_bubble ? '0 : sel_a;
      ex_fwd_b <= id_bubble ? '0 : sel_b;
    end
  end

  // Saturating stall/flush event counters.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_count <= '0;
      flush_count <= '0;
    end else begin
      if (stall && (stall_count != '1)) stall_count <= stall_count + 1'b1;
      if (ex_flush && (flush_count != '1)) flush_count <= flush_count + 1'b1;
    end
  end

endmodule

// File: doc/pipeline_hazard_scoreboard.md
# pipeline_hazard_scoreboard

Parametrised hazard, forwarding and flush controller for the pipelined ARM-subset CPU, replacing the fixed EX/MEM/WB compare logic with a DEPTH-entry in-flight scoreboard. It sits beside the ID/EX pipeline register and works out three things: when decode must stall, when the decoded instruction must be turned into a bubble, and which forwarding source each EX operand uses. It also covers flag-setting-to-conditional-branch hazards and keeps saturating stall/flush performance counters.

## Interface
Parameters:
- DEPTH, 3, pipeline stages after ID that can hold a register writer (stage 1 = EX … stage DEPTH = WB); legal range 2..8
- AW, 5, register address width
- ZERO_REG, 31, register index that is never a hazard source (XZR)
- LOAD_LAT, 2, stage number at whose end load data exists; legal range 1..DEPTH-1
- CW, 16, performance counter width

Ports:
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  asynchronous, active-low; clears all state
- id_valid  in  1  ID stage holds a real instruction
- id_rn, id_rm  in  AW  source registers of the ID instruction
- id_rn_used, id_rm_used  in  1  the matching source is actually read
- id_wr_en  in  1  ID instruction writes a register
- id_rd  in  AW  destination of the ID instruction (X30 already substituted for BL)
- id_is_load  in  1  ID instruction is LDUR
- id_sets_flags  in  1  ID instruction updates NZVC
- id_uses_flags  in  1  ID instruction is B.cond, which reads the flags
- ex_flush  in  1  taken branch resolved in EX this cycle
- stall  out  1  combinational; hold PC and IF/ID
- id_bubble  out  1  combinational; ID/EX loads zero controls
- ex_fwd_a, ex_fwd_b  out  $clog2(DEPTH)  registered forwarding select for the instruction now in EX
- stall_count, flush_count  out  CW  saturating event counters

## Operation
- The scoreboard has entries e[0..DEPTH-1], where e[i] tracks stage i+1. Each entry holds {valid, wr, rd, load, flags}.
- Every cycle, e[i] <= e[i-1] for i ≥ 1. Entry e[0] loads the ID instruction when it advances, and a bubble otherwise (valid = 0).
- An entry matches operand r when all of these hold: valid, wr, rd == r, r != ZERO_REG, and the operand is used.
- For each used operand, find the lowest i in 0..DEPTH-2 that matches. The youngest match wins. A match only in e[DEPTH-1] forwards nothing, because the register file writes on the falling edge and the read sees the new value.
- Load-use stall: stall when the winning match is a load and i+1 < LOAD_LAT.
- Flag stall: stall when id_uses_flags is set and e[0] is valid with flags set.
- stall = id_valid & ~ex_flush & (load-use | flag stall).
- id_bubble = stall | ex_flush | ~id_valid.
- Advance rule: when id_bubble = 0, e[0] <= {1, id_wr, id_rd, id_is_load, id_sets_flags}.
- Forward selects, per operand:
  - Next value is i+1 when operand 0 or 1 wins at index i.
  - Next value is 0 when no operand wins or the instruction does not advance.
  - Select 1 means the EX/MEM ALU result; select k means the output of stage k's pipeline register.
- ex_flush has priority over stall. The ID instruction is killed (e[0] gets a bubble, selects go to 0) and stall is forced low. Older entries shift normally.
- stall_count increments on each cycle with stall = 1. flush_count increments on each cycle with ex_flush = 1. Both saturate at 2^CW-1 and never wrap.

## Timing
- Reset value of every output is 0. While reset is low, stall and id_bubble are held at 0 and 1 respectively.
- Reset asserted mid-operation clears all entries and counters immediately. No hazard persists past reset.
- stall and id_bubble are combinational from the ID inputs and e[].
- ex_fwd_a and ex_fwd_b have one-cycle latency. They are valid during the cycle the instruction occupies EX.
- A load followed by a dependent instruction costs exactly LOAD_LAT-1 stall cycles.
- A flag-setting instruction followed by B.cond costs exactly 1 stall cycle.
- An ALU-to-ALU dependency costs 0 stall cycles.
- If an instruction has stall and ex_flush in the same cycle, it is flushed and not counted as stalled.

## Test plan
- Back-to-back ALU dependency, DEPTH=3: ADDS X1 then ADD X2,X1,X1 -> no stall; the second instruction sees ex_fwd_a=1 and ex_fwd_b=1 in EX.
- Load-use, LOAD_LAT=2: LDUR X3 then ADD X4,X3,X5 -> stall=1 for one cycle and one bubble; the ADD then enters EX with ex_fwd_a=2 and ex_fwd_b=0; stall_count=1.
- Distance-3 and XZR cases: a writer of X7 three instructions ahead -> select 0 (register file). A writer of X31 immediately ahead -> select 0, no stall.
- Flags: SUBS then B.LT -> exactly one stall cycle. Assert ex_flush in that stall cycle -> stall=0, id_bubble=1, flush_count=1, stall_count unchanged.
- Parameter sweep with DEPTH=5, LOAD_LAT=3: load then dependent -> 2 stall cycles, then ex_fwd=3. Drive 70000 stalls with CW=16 -> stall_count holds at 65535.
- Assert reset low mid-stall -> all outputs 0 except id_bubble=1 at once. After release, the first dependent instruction sees no stale hazard.
